// File: rtl/mem_arbiter.sv
// Three-slot round-robin memory arbiter. A one-hot IDLE/ISSUE/RELEASE FSM forwards one
// requester at a time to a single memory port and aborts accesses that take too long.
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] req_address,
  input  logic [47:0] req_data,
  input  logic [5:0]  req_request,
  input  logic [2:0]  req_we,
  output logic [2:0]  req_done,
  output logic [15:0] req_rdata,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data,
  output logic [1:0]  mem_request,
  output logic        mem_we,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ISSUE   = 3'b010,
    RELEASE = 3'b100
  } state_t;

  // TIMEOUT of 0 wraps to a limit of 255, giving a 256-cycle window.
  localparam logic [7:0] CNT_LIMIT = TIMEOUT - 8'd1;
  localparam logic [1:0] NO_GRANT  = 2'b11;

  state_t      state_reg, state_next;
  logic [1:0]  rr_reg, rr_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] mem_address_reg, mem_address_next;
  logic [15:0] mem_data_reg, mem_data_next;
  logic [1:0]  mem_request_reg, mem_request_next;
  logic        mem_we_reg, mem_we_next;
  logic [2:0]  req_done_reg, req_done_next;
  logic [15:0] req_rdata_reg, req_rdata_next;
  logic [1:0]  grant_reg, grant_next;
  logic        timeout_err_reg, timeout_err_next;

  // Four-entry slot views so a 2-bit index never leaves range; entry 3 is never pending.
  logic [15:0] slot_addr [4];
  logic [15:0] slot_data [4];
  logic [1:0]  slot_req  [4];
  logic [3:0]  slot_we;
  logic [3:0]  pending;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < 3) begin : g_real
        assign slot_addr[gi] = req_address[16*gi +: 16];
        assign slot_data[gi] = req_data[16*gi +: 16];
        assign slot_req[gi]  = req_request[2*gi +: 2];
        assign slot_we[gi]   = req_we[gi];
        assign pending[gi]   = |req_request[2*gi +: 2];
      end else begin : g_pad
        assign slot_addr[gi] = 16'h0000;
        assign slot_data[gi] = 16'h0000;
        assign slot_req[gi]  = 2'b00;
        assign slot_we[gi]   = 1'b0;
        assign pending[gi]   = 1'b0;
      end
    end
  endgenerate

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return (s >= 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  logic [1:0] cand0, cand1, cand2;
  logic [1:0] sel_slot;
  logic       sel_valid;

  always_comb begin
    cand0     = rr_reg;
    cand1     = next_slot(cand0);
    cand2     = next_slot(cand1);
    sel_valid = |pending;
    if (pending[cand0])      sel_slot = cand0;
    else if (pending[cand1]) sel_slot = cand1;
    else                     sel_slot = cand2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      rr_reg          <= 2'd0;
      cnt_reg         <= 8'd0;
      mem_address_reg <= 16'h0000;
      mem_data_reg    <= 16'h0000;
      mem_request_reg <= 2'b00;
      mem_we_reg      <= 1'b0;
      req_done_reg    <= 3'b000;
      req_rdata_reg   <= 16'h0000;
      grant_reg       <= NO_GRANT;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_reg          <= rr_next;
      cnt_reg         <= cnt_next;
      mem_address_reg <= mem_address_next;
      mem_data_reg    <= mem_data_next;
      mem_request_reg <= mem_request_next;
      mem_we_reg      <= mem_we_next;
      req_done_reg    <= req_done_next;
      req_rdata_reg   <= req_rdata_next;
      grant_reg       <= grant_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_next          = rr_reg;
    cnt_next         = cnt_reg;
    mem_address_next = mem_address_reg;
    mem_data_next    = mem_data_reg;
    mem_request_next = mem_request_reg;
    mem_we_next      = mem_we_reg;
    req_done_next    = 3'b000;
    req_rdata_next   = req_rdata_reg;
    grant_next       = grant_reg;
    timeout_err_next = timeout_err_reg;

    case (state_reg)
      IDLE: begin
        grant_next       = NO_GRANT;
        mem_address_next = 16'h0000;
        mem_data_next    = 16'h0000;
        mem_request_next = 2'b00;
        mem_we_next      = 1'b0;
        if (sel_valid) begin
          mem_address_next = slot_addr[sel_slot];
          mem_data_next    = slot_data[sel_slot];
          mem_request_next = slot_req[sel_slot];
          mem_we_next      = slot_we[sel_slot];
          grant_next       = sel_slot;
          cnt_next         = 8'd0;
          state_next       = ISSUE;
        end
      end

      ISSUE: begin
        // Completion is checked first so it wins over a timeout on the same edge.
        if (mem_done || (cnt_reg == CNT_LIMIT)) begin
          mem_address_next = 16'h0000;
          mem_data_next    = 16'h0000;
          mem_request_next = 2'b00;
          mem_we_next      = 1'b0;
          req_done_next    = 3'b001 << grant_reg;
          rr_next          = next_slot(grant_reg);
          state_next       = RELEASE;
          if (mem_done) begin
            req_rdata_next = mem_rdata;
          end else begin
            req_rdata_next   = 16'h0000;
            timeout_err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      RELEASE: begin
        grant_next = NO_GRANT;
        state_next = IDLE;
      end

      default: begin
        state_next       = IDLE;
        grant_next       = NO_GRANT;
        mem_address_next = 16'h0000;
        mem_data_next    = 16'h0000;
        mem_request_next = 2'b00;
        mem_we_next      = 1'b0;
      end
    endcase
  end

  assign req_done    = req_done_reg;
  assign req_rdata   = req_rdata_reg;
  assign mem_address = mem_address_reg;
  assign mem_data    = mem_data_reg;
  assign mem_request = mem_request_reg;
  assign mem_we      = mem_we_reg;
  assign grant       = grant_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/completions,
// a monitor pops and compares them, and a memory responder answers after a set delay.
module tb_mem_arbiter;
  localparam logic [7:0] TO = 8'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] req_address, req_data;
  logic [5:0]  req_request;
  logic [2:0]  req_we;
  logic [2:0]  req_done;
  logic [15:0] req_rdata, mem_address, mem_data, mem_rdata;
  logic [1:0]  mem_request, grant;
  logic        mem_we, mem_done, timeout_err;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_address(req_address), .req_data(req_data),
    .req_request(req_request), .req_we(req_we),
    .req_done(req_done), .req_rdata(req_rdata),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_request(mem_request), .mem_we(mem_we),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  slot;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  req;
    logic        we;
  } grant_t;
  typedef struct {
    logic [1:0]  slot;
    logic [15:0] rdata;
  } done_t;

  grant_t gq[$];
  done_t  dq[$];
  int tests = 0;
  int fails = 0;
  int last_grant_cyc = 0;
  int resp_delay = 0;
  logic [15:0] resp_data = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_grant(input logic [1:0] s, input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] r, input logic w);
    grant_t g;
    g.slot = s; g.addr = a; g.data = d; g.req = r; g.we = w;
    gq.push_back(g);
  endtask

  task automatic exp_done(input logic [1:0] s, input logic [15:0] rd);
    done_t e;
    e.slot = s; e.rdata = rd;
    dq.push_back(e);
  endtask

  task automatic set_slot(input int i, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] r, input logic w);
    req_address[16*i +: 16] = a;
    req_data[16*i +: 16]    = d;
    req_request[2*i +: 2]   = r;
    req_we[i]               = w;
  endtask

  // Waits for a completion pulse; the finished owner drops its request unless kept.
  task automatic wait_done(input logic [2:0] keep, output int slot, output int done_cyc);
    slot = -1;
    done_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_done != 3'b000) begin
        done_cyc = cyc;
        for (int i = 0; i < 3; i++)
          if (req_done[i]) begin
            slot = i;
            if (!keep[i]) req_request[2*i +: 2] = 2'b00;
          end
        break;
      end
    end
    if (slot < 0) check("wait_done_expired", {29'd0, req_done}, 32'h7);
  endtask

  // Memory responder: asserts mem_done resp_delay cycles into an access (0 = never).
  initial begin
    int rcnt;
    rcnt = 0;
    mem_done = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_request != 2'b00) begin
        rcnt++;
        mem_done = (resp_delay != 0) && (rcnt == resp_delay);
      end else begin
        rcnt = 0;
        mem_done = 1'b0;
      end
      mem_rdata = resp_data;
    end
  end

  // Monitor: compares every new grant and every completion pulse against the queues.
  initial begin
    logic [1:0] prev_g;
    grant_t g;
    done_t  d;
    prev_g = 2'b11;
    forever begin
      @(negedge clk);
      if (grant != 2'b11 && prev_g == 2'b11) begin
        last_grant_cyc = cyc;
        if (gq.size() == 0) check("grant_unexpected", {30'd0, grant}, 32'h3);
        else begin
          g = gq.pop_front();
          check("grant_slot", {30'd0, grant}, {30'd0, g.slot});
          check("mem_address", {16'd0, mem_address}, {16'd0, g.addr});
          check("mem_data", {16'd0, mem_data}, {16'd0, g.data});
          check("mem_request", {30'd0, mem_request}, {30'd0, g.req});
          check("mem_we", {31'd0, mem_we}, {31'd0, g.we});
        end
      end
      if (req_done != 3'b000) begin
        if (dq.size() == 0) check("done_unexpected", {29'd0, req_done}, 32'h0);
        else begin
          d = dq.pop_front();
          check("req_done", {29'd0, req_done}, {29'd0, 3'b001 << d.slot});
          check("req_rdata", {16'd0, req_rdata}, {16'd0, d.rdata});
        end
      end
      prev_g = grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, dc, t0;
    int gc [4];
    reset = 1'b0;
    req_address = '0; req_data = '0; req_request = '0; req_we = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'h3);
    check("rst_mem_address", {16'd0, mem_address}, 32'h0);
    check("rst_mem_data", {16'd0, mem_data}, 32'h0);
    check("rst_mem_request", {30'd0, mem_request}, 32'h0);
    check("rst_mem_we", {31'd0, mem_we}, 32'h0);
    check("rst_req_done", {29'd0, req_done}, 32'h0);
    check("rst_req_rdata", {16'd0, req_rdata}, 32'h0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'h0);
    reset = 1'b1;

    // Slot 1 write, memory answers 3 cycles after issue; owner inputs change mid-access.
    resp_delay = 3; resp_data = 16'h1111;
    exp_grant(2'd1, 16'h1234, 16'hBEEF, 2'b11, 1'b1);
    exp_done(2'd1, 16'h1111);
    set_slot(1, 16'h1234, 16'hBEEF, 2'b11, 1'b1);
    t0 = cyc;
    @(negedge clk);
    check("a_latency", last_grant_cyc, t0 + 1);
    req_address[31:16] = 16'hFFFF;
    @(negedge clk);
    check("a_hold_addr", {16'd0, mem_address}, 32'h1234);
    check("a_hold_grant", {30'd0, grant}, 32'h1);
    wait_done(3'b000, s, dc);
    check("a_done_delay", dc - last_grant_cyc, 3);
    check("a_mem_cleared", {30'd0, mem_request}, 32'h0);
    @(negedge clk);
    check("a_grant_release", {30'd0, grant}, 32'h3);
    check("a_done_single", {29'd0, req_done}, 32'h0);

    // Slot 2 low-byte read; read data must persist after the pulse.
    resp_delay = 2; resp_data = 16'h5A5A;
    exp_grant(2'd2, 16'h0042, 16'h0000, 2'b01, 1'b0);
    exp_done(2'd2, 16'h5A5A);
    set_slot(2, 16'h0042, 16'h0000, 2'b01, 1'b0);
    wait_done(3'b000, s, dc);
    repeat (3) @(negedge clk);
    check("b_rdata_hold", {16'd0, req_rdata}, 32'h5A5A);

    // All three slots at once with immediate completion: grants 0,1,2 three cycles apart.
    resp_delay = 1; resp_data = 16'hC0DE;
    exp_grant(2'd0, 16'h0010, 16'h1010, 2'b11, 1'b1);
    exp_grant(2'd1, 16'h0020, 16'h2020, 2'b10, 1'b0);
    exp_grant(2'd2, 16'h0030, 16'h3030, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) exp_done(i[1:0], 16'hC0DE);
    set_slot(0, 16'h0010, 16'h1010, 2'b11, 1'b1);
    set_slot(1, 16'h0020, 16'h2020, 2'b10, 1'b0);
    set_slot(2, 16'h0030, 16'h3030, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_done(3'b000, s, dc);
      gc[i] = last_grant_cyc;
      check("c_order", s, i);
    end
    check("c_spacing01", gc[1] - gc[0], 3);
    check("c_spacing12", gc[2] - gc[1], 3);
    repeat (2) @(negedge clk);

    // Slots 0 and 2 both re-request continuously: 0,2,0,2.
    resp_delay = 1; resp_data = 16'hD00D;
    for (int i = 0; i < 2; i++) begin
      exp_grant(2'd0, 16'h0100, 16'h00A0, 2'b10, 1'b1);
      exp_done(2'd0, 16'hD00D);
      exp_grant(2'd2, 16'h0300, 16'h0000, 2'b11, 1'b0);
      exp_done(2'd2, 16'hD00D);
    end
    set_slot(0, 16'h0100, 16'h00A0, 2'b10, 1'b1);
    set_slot(2, 16'h0300, 16'h0000, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_done(3'b101, s, dc);
      check("d_order", s, (i % 2 == 0) ? 0 : 2);
    end
    req_request = '0;
    repeat (2) @(negedge clk);

    // mem_done on the same edge as the timeout: completion wins.
    resp_delay = 4; resp_data = 16'h7777;
    exp_grant(2'd1, 16'h0777, 16'h1234, 2'b11, 1'b1);
    exp_done(2'd1, 16'h7777);
    set_slot(1, 16'h0777, 16'h1234, 2'b11, 1'b1);
    wait_done(3'b000, s, dc);
    check("e_tie_delay", dc - last_grant_cyc, 4);
    check("e_tie_no_err", {31'd0, timeout_err}, 32'h0);
    repeat (2) @(negedge clk);

    // No response at all: abort after 4 ISSUE cycles, rdata zeroed, sticky error.
    resp_delay = 0;
    exp_grant(2'd0, 16'h0ABC, 16'h0000, 2'b11, 1'b0);
    exp_done(2'd0, 16'h0000);
    set_slot(0, 16'h0ABC, 16'h0000, 2'b11, 1'b0);
    wait_done(3'b000, s, dc);
    check("f_abort_delay", dc - last_grant_cyc, 4);
    check("f_timeout_err", {31'd0, timeout_err}, 32'h1);
    repeat (2) @(negedge clk);
    resp_delay = 2; resp_data = 16'hABCD;
    exp_grant(2'd2, 16'h0222, 16'h0000, 2'b01, 1'b0);
    exp_done(2'd2, 16'hABCD);
    set_slot(2, 16'h0222, 16'h0000, 2'b01, 1'b0);
    wait_done(3'b000, s, dc);
    check("f_err_sticky", {31'd0, timeout_err}, 32'h1);
    repeat (2) @(negedge clk);

    // Reset in the middle of an access: no pulse, everything cleared, slot 0 first after.
    resp_delay = 0;
    exp_grant(2'd1, 16'h0111, 16'h5555, 2'b11, 1'b1);
    set_slot(1, 16'h0111, 16'h5555, 2'b11, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant == 2'd1) break;
    end
    check("g_granted", {30'd0, grant}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("g_rst_grant", {30'd0, grant}, 32'h3);
    check("g_rst_mem_request", {30'd0, mem_request}, 32'h0);
    check("g_rst_mem_address", {16'd0, mem_address}, 32'h0);
    check("g_rst_req_rdata", {16'd0, req_rdata}, 32'h0);
    check("g_rst_timeout_err", {31'd0, timeout_err}, 32'h0);
    set_slot(0, 16'h0AAA, 16'h0BBB, 2'b10, 1'b0);
    set_slot(2, 16'h0CCC, 16'h0DDD, 2'b01, 1'b1);
    @(negedge clk);
    check("g_rst_req_done", {29'd0, req_done}, 32'h0);
    resp_delay = 2; resp_data = 16'h3C3C;
    exp_grant(2'd0, 16'h0AAA, 16'h0BBB, 2'b10, 1'b0);
    exp_done(2'd0, 16'h3C3C);
    reset = 1'b1;
    t0 = cyc;
    wait_done(3'b000, s, dc);
    req_request = '0;
    check("g_first_grant_cyc", last_grant_cyc, t0 + 1);
    check("g_first_slot", s, 0);
    repeat (4) @(negedge clk);
    check("grant_queue_left", gq.size(), 0);
    check("done_queue_left", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
